// File: rtl/alu_issue.sv
// alu_issue: registered RV32I decode/issue stage feeding the ALU request.
// The instruction is decoded on the input side and stored already decoded in a
// two-entry skid buffer (main + skid). All outputs, including in_ready, come
// straight from flops.
//
// Handshake semantics (both ports): a beat transfers on a rising edge where
// valid && ready. A producer never drops valid and never changes its payload
// until the transfer happens. in_ready does not depend on out_ready within the
// same cycle; it is recomputed from the next buffer state and registered.

package Bundle;

   // ALU function codes; ALU_ADD is the all-zero code so cleared payload flops
   // present a harmless ADD of 0 + 0.
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_fun_e;

   typedef struct packed {
      alu_fun_e    fun;
      logic [31:0] op1;
      logic [31:0] op2;
   } AluIn;

endpackage

module alu_issue #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   output logic            out_valid,
   input  logic            out_ready,
   output Bundle::AluIn    out_alu,
   output logic [4:0]      out_rd,
   output logic            out_wb_en,
   output logic            out_illegal,
   output logic [1:0]      dbg_state
);

   import Bundle::*;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // One decoded beat as held in the buffer.
   typedef struct packed {
      AluIn       alu;
      logic [4:0] rd;
      logic       wb_en;
      logic       illegal;
   } issue_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   // f3 -> ALU function for OP / OP-IMM; alt picks SUB (000) or SRA (101).
   function automatic alu_fun_e f3_fun(input logic [2:0] f3, input logic alt);
      alu_fun_e fun;
      case (f3)
         3'b000:  fun = alt ? ALU_SUB : ALU_ADD;
         3'b001:  fun = ALU_SLL;
         3'b010:  fun = ALU_SLT;
         3'b011:  fun = ALU_SLTU;
         3'b100:  fun = ALU_XOR;
         3'b101:  fun = alt ? ALU_SRA : ALU_SRL;
         3'b110:  fun = ALU_OR;
         default: fun = ALU_AND;
      endcase
      return fun;
   endfunction

   // Instruction fields and immediates
   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic        f7b5;
   logic        f7_zero;
   logic        f7_alt;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_u;
   logic [31:0] shamt;

   assign opcode  = in_inst[6:0];
   assign f3      = in_inst[14:12];
   assign f7      = in_inst[31:25];
   assign f7b5    = in_inst[30];
   assign f7_zero = (f7 == 7'b0000000);
   assign f7_alt  = (f7 == 7'b0100000);
   assign imm_i   = {{20{in_inst[31]}}, in_inst[31:20]};
   assign imm_s   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign imm_u   = {in_inst[31:12], 12'b0};
   assign shamt   = {27'b0, in_inst[24:20]};

   issue_t dec;
   logic   op_legal;
   logic   imm_legal;

   // Combinational decode of the incoming beat; illegal beats carry ADD 0,0.
   always_comb begin
      dec         = '0;
      dec.alu.fun = ALU_ADD;
      dec.rd      = in_inst[11:7];
      op_legal    = f7_zero || (f7_alt && ((f3 == 3'b000) || (f3 == 3'b101)));
      imm_legal   = 1'b1;
      if (f3 == 3'b001) begin
         imm_legal = f7_zero;
      end else if (f3 == 3'b101) begin
         imm_legal = f7_zero || f7_alt;
      end

      case (opcode)
         OPC_OP: begin
            if (op_legal) begin
               dec.alu.fun = f3_fun(f3, f7b5);
               dec.alu.op1 = in_rs1_data;
               dec.alu.op2 = in_rs2_data;
               dec.wb_en   = 1'b1;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            if (imm_legal) begin
               // Only SRAI uses the alternate bit; ADDI has no SUB form.
               dec.alu.fun = f3_fun(f3, f7b5 && (f3 == 3'b101));
               dec.alu.op1 = in_rs1_data;
               dec.alu.op2 = ((f3 == 3'b001) || (f3 == 3'b101)) ? shamt : imm_i;
               dec.wb_en   = 1'b1;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OPC_LUI: begin
            dec.alu.op2 = imm_u;
            dec.wb_en   = 1'b1;
         end
         OPC_AUIPC: begin
            dec.alu.op1 = in_pc;
            dec.alu.op2 = imm_u;
            dec.wb_en   = 1'b1;
         end
         OPC_JAL, OPC_JALR: begin
            // ALU produces the link value pc + 4.
            dec.alu.op1 = in_pc;
            dec.alu.op2 = 32'd4;
            dec.wb_en   = 1'b1;
         end
         OPC_LOAD: begin
            dec.alu.op1 = in_rs1_data;
            dec.alu.op2 = imm_i;
            dec.wb_en   = 1'b1;
         end
         OPC_STORE: begin
            dec.alu.op1 = in_rs1_data;
            dec.alu.op2 = imm_s;
         end
         OPC_BRANCH: begin
            dec.alu.fun = ALU_SUB;
            dec.alu.op1 = in_rs1_data;
            dec.alu.op2 = in_rs2_data;
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase

      // x0 is never written.
      if (dec.rd == 5'd0) begin
         dec.wb_en = 1'b0;
      end
   end

   // Skid buffer state
   state_e state_q, state_d;
   issue_t main_q, main_d;
   issue_t skid_q, skid_d;
   logic   in_ready_q, in_ready_d;
   logic   out_valid_q, out_valid_d;
   logic   in_fire;
   logic   out_fire;

   assign in_fire  = in_valid && in_ready_q;
   assign out_fire = out_valid_q && out_ready;

   // Next-state and buffer loads; main always holds the oldest beat.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               state_d = ST_ONE;
               main_d  = dec;
            end
         end
         ST_ONE: begin
            if (in_fire && !out_fire) begin
               state_d = ST_TWO;
               skid_d  = dec;
            end else if (out_fire && !in_fire) begin
               state_d = ST_EMPTY;
            end else if (in_fire && out_fire) begin
               main_d  = dec;
            end
         end
         ST_TWO: begin
            // in_ready is low here, so only the drain side can move.
            if (out_fire) begin
               state_d = ST_ONE;
               main_d  = skid_q;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
      out_valid_d = (state_d != ST_EMPTY);
      in_ready_d  = (state_d != ST_TWO);
   end

   // State, handshake and payload registers; reset clears everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         main_q      <= '0;
         skid_q      <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_alu     = main_q.alu;
   assign out_rd      = main_q.rd;
   assign out_wb_en   = main_q.wb_en;
   assign out_illegal = main_q.illegal;
   assign dbg_state   = state_q;

endmodule

// File: doc/alu_issue.md
# alu_issue

Registered decode/issue stage that drives the ALU's `Bundle::AluIn` request. It accepts one RV32I instruction per handshake, along with its PC and register-file read data. It decodes the ALU function, selects and sign-extends operands, and presents `{fun, op1, op2}` plus writeback metadata to the execute stage through a valid/ready interface. A two-entry skid buffer gives full throughput with a fully registered `in_ready`.

## Interface

- `XLEN`, 32, datapath width; only 32 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  instruction beat valid.
- `in_ready`  out  1  stage can accept a beat; driven directly from a flop.
- `in_inst`  in  32  instruction word.
- `in_pc`  in  32  instruction PC.
- `in_rs1_data`  in  32  rs1 register value.
- `in_rs2_data`  in  32  rs2 register value.
- `out_valid`  out  1  issue beat valid.
- `out_ready`  in  1  execute stage accepts the beat.
- `out_alu`  out  `Bundle::AluIn`  `{fun, op1, op2}` to the ALU.
- `out_rd`  out  5  destination register.
- `out_wb_en`  out  1  result is written to `out_rd`; forced to 0 when `out_rd == 0`.
- `out_illegal`  out  1  opcode or funct not decodable.

## Operation

- **Fields:** opcode = `inst[6:0]`, f3 = `inst[14:12]`, f7b5 = `inst[30]`.
- **Immediates** (sign-extended to 32 bits): I = `inst[31:20]`; S = `{inst[31:25], inst[11:7]}`; U = `{inst[31:12], 12'b0}`.
- **OP (0110011):** op1 = rs1, op2 = rs2. f3 map:
  - 000: ADD, or SUB if f7b5.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
  - 101: SRL, or SRA if f7b5.
  - 110: OR. 111: AND.
  - `wb_en` = 1. Illegal if `inst[31:25]` is not 0000000 or 0100000, or if 0100000 is used with f3 other than 000/101.
- **OP-IMM (0010011):** op1 = rs1, op2 = I-imm. Same f3 map, except f3=000 is always ADD.
  - Shifts (f3 = 001/101): op2 = `{27'b0, inst[24:20]}`; f7b5 selects SRA only for f3=101.
  - Illegal if shift `inst[31:25]` is not 0000000, or 0100000 for SRAI.
- **LUI (0110111):** ADD, op1 = 0, op2 = U-imm.
- **AUIPC (0010111):** ADD, op1 = pc, op2 = U-imm.
- **JAL (1101111), JALR (1100111):** ADD, op1 = pc, op2 = 4 (link value). `wb_en` = 1.
- **LOAD (0000011):** ADD, op1 = rs1, op2 = I-imm, `wb_en` = 1.
- **STORE (0100011):** ADD, op1 = rs1, op2 = S-imm, `wb_en` = 0.
- **BRANCH (1100011):** SUB, op1 = rs1, op2 = rs2, `wb_en` = 0.
- **Any other opcode:** `illegal` = 1, fun = ADD, op1 = op2 = 0, `wb_en` = 0. The beat is still issued.
- **Skid buffer:** a main register feeds the outputs; a skid register catches the beat accepted while output is stalled.
  - States: EMPTY, ONE (main valid), TWO (main and skid valid).
  - `in_ready` = (state != TWO), registered.
  - EMPTY --in fire--> ONE.
  - ONE --in fire, no out fire--> TWO.
  - ONE --out fire, no in fire--> EMPTY.
  - ONE --both fire--> ONE (main reloads from input).
  - TWO --out fire--> ONE (main loads from skid). No input is accepted in TWO.
- Decode is combinational on the input side and is stored already decoded; outputs come only from flops.

## Timing

- Latency: a beat accepted at edge N is presented with `out_valid` = 1 after edge N.
- Throughput: 1 beat/cycle while `out_ready` = 1.
- Handshake:
  - A beat transfers when valid && ready at a rising edge.
  - `out_*` payload is held stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a transfer.
  - `in_ready` does not depend combinationally on `out_ready`.
- Ordering: beats leave in acceptance order; no drop, no duplication.
- Reset (asynchronous, any time including mid-transfer):
  - State = EMPTY, `out_valid` = 0, `in_ready` = 1.
  - All payload flops = 0, so `out_alu.fun` = ALU_ADD encoding, op1 = op2 = 0.
  - Buffered beats are discarded.
  - On the first edge after deassertion the stage may accept input.
- `in_valid` = 0 with `in_ready` = 1: no state change.

## Test plan

- ADDI x1,x0,5 (0x00500093), rs1 = 0x10 -> one cycle later: fun = ADD, op1 = 0x10, op2 = 5, rd = 1, wb_en = 1, illegal = 0.
- SUB x2,x1,x2 (0x40208133), rs1 = 9, rs2 = 4 -> fun = SUB, op1 = 9, op2 = 4. SRAI x3,x1,4 (0x4040D193) -> fun = SRA, op2 = 4.
- LUI x5,0x12345 (0x123452B7) -> ADD, op1 = 0, op2 = 0x12345000. AUIPC at pc = 0x100 with the same imm -> op1 = 0x100. SW imm = -4 -> op2 = 0xFFFFFFFC, wb_en = 0.
- Back-to-back stream of 8 beats; `out_ready` low for 3 cycles from cycle 2 -> `in_ready` drops only once two beats are held; output order and payloads are preserved; payload is stable while stalled.
- 0xFFFFFFFF, and ADD with f7 = 0000001 -> illegal = 1, wb_en = 0, op1 = op2 = 0.
- Assert reset while in state TWO -> `out_valid` = 0 and `in_ready` = 1 immediately without a clock edge; held beats never appear.
